// File: rtl/axi_beat_master.sv
// axi_beat_master
// Single-beat AXI4-Lite style master sitting behind the cache data transfer
// stage. Each beat takes the stage's current address (and write word), runs
// one AXI read (AR then R) or write (AW+W then B) transaction, and returns a
// one-cycle done pulse so the stage can advance its counter, address and FIFO.
// A one-cycle GAP after each beat lets the stage settle before resampling.
//
// Ports:
//   clk, arst            clock, synchronous active-high reset
//   i_req_read/_write    level requests from the cache FSM (sampled in IDLE)
//   i_count_done         transfer stage reports all beats complete
//   i_addr, i_wdata      beat address / write word from the transfer stage
//   o_rdata              registered read word
//   o_axi_done           one-cycle pulse per completed beat
//   o_busy               high whenever not IDLE
//   o_error              sticky flag, any non-OKAY response
//   m_axi_*              AR, R, AW, W, B channels
module axi_beat_master #(
  parameter int AXI_DATA_WIDTH = 32,
  parameter int AXI_ADDR_WIDTH = 64,
  parameter int AXI_STRB_WIDTH = AXI_DATA_WIDTH / 8
) (
  input  logic                      clk,
  input  logic                      arst,
  input  logic                      i_req_read,
  input  logic                      i_req_write,
  input  logic                      i_count_done,
  input  logic [AXI_ADDR_WIDTH-1:0] i_addr,
  input  logic [AXI_DATA_WIDTH-1:0] i_wdata,
  output logic [AXI_DATA_WIDTH-1:0] o_rdata,
  output logic                      o_axi_done,
  output logic                      o_busy,
  output logic                      o_error,
  output logic [AXI_ADDR_WIDTH-1:0] m_axi_araddr,
  output logic                      m_axi_arvalid,
  input  logic                      m_axi_arready,
  input  logic [AXI_DATA_WIDTH-1:0] m_axi_rdata,
  input  logic [1:0]                m_axi_rresp,
  input  logic                      m_axi_rvalid,
  output logic                      m_axi_rready,
  output logic [AXI_ADDR_WIDTH-1:0] m_axi_awaddr,
  output logic                      m_axi_awvalid,
  input  logic                      m_axi_awready,
  output logic [AXI_DATA_WIDTH-1:0] m_axi_wdata,
  output logic [AXI_STRB_WIDTH-1:0] m_axi_wstrb,
  output logic                      m_axi_wvalid,
  input  logic                      m_axi_wready,
  input  logic [1:0]                m_axi_bresp,
  input  logic                      m_axi_bvalid,
  output logic                      m_axi_bready
);

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_AR   = 3'd1,
    ST_R    = 3'd2,
    ST_AWW  = 3'd3,
    ST_B    = 3'd4,
    ST_GAP  = 3'd5
  } state_e;

  state_e                    state_q, state_d;
  logic [AXI_ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [AXI_DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [AXI_DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic                      awvalid_q, awvalid_d;
  logic                      wvalid_q, wvalid_d;
  logic                      done_q, done_d;
  logic                      error_q, error_d;

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    rdata_d   = rdata_q;
    awvalid_d = awvalid_q;
    wvalid_d  = wvalid_q;
    done_d    = 1'b0;
    error_d   = error_q;

    case (state_q)
      ST_IDLE: begin
        // Read has priority when both requests are up.
        if (!i_count_done && i_req_read) begin
          addr_d  = i_addr;
          state_d = ST_AR;
        end else if (!i_count_done && i_req_write) begin
          addr_d    = i_addr;
          wdata_d   = i_wdata;
          awvalid_d = 1'b1;
          wvalid_d  = 1'b1;
          state_d   = ST_AWW;
        end
      end
      ST_AR: begin
        if (m_axi_arready) state_d = ST_R;
      end
      ST_R: begin
        if (m_axi_rvalid) begin
          rdata_d = m_axi_rdata;
          done_d  = 1'b1;
          if (m_axi_rresp != 2'b00) error_d = 1'b1;
          state_d = ST_GAP;
        end
      end
      ST_AWW: begin
        // AW and W retire independently; each valid drops after its own
        // handshake and stays low for the rest of the beat.
        if (awvalid_q && m_axi_awready) awvalid_d = 1'b0;
        if (wvalid_q && m_axi_wready)   wvalid_d  = 1'b0;
        if (!awvalid_d && !wvalid_d)    state_d   = ST_B;
      end
      ST_B: begin
        if (m_axi_bvalid) begin
          done_d  = 1'b1;
          if (m_axi_bresp != 2'b00) error_d = 1'b1;
          state_d = ST_GAP;
        end
      end
      ST_GAP:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (arst) begin
      state_q   <= ST_IDLE;
      addr_q    <= '0;
      wdata_q   <= '0;
      rdata_q   <= '0;
      awvalid_q <= 1'b0;
      wvalid_q  <= 1'b0;
      done_q    <= 1'b0;
      error_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      rdata_q   <= rdata_d;
      awvalid_q <= awvalid_d;
      wvalid_q  <= wvalid_d;
      done_q    <= done_d;
      error_q   <= error_d;
    end
  end

  // The done pulse is registered together with the read word, so the
  // transfer stage sees both in the GAP cycle and can push o_rdata into its
  // FIFO on the same pulse that advances its counter.
  assign o_rdata       = rdata_q;
  assign o_axi_done    = done_q;
  assign o_busy        = (state_q != ST_IDLE);
  assign o_error       = error_q;

  assign m_axi_araddr  = addr_q;
  assign m_axi_arvalid = (state_q == ST_AR);
  assign m_axi_rready  = (state_q == ST_R);
  assign m_axi_awaddr  = addr_q;
  assign m_axi_awvalid = awvalid_q;
  assign m_axi_wdata   = wdata_q;
  assign m_axi_wstrb   = '1;
  assign m_axi_wvalid  = wvalid_q;
  assign m_axi_bready  = (state_q == ST_B);

endmodule
